// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: input conditioning, 11-bit frame capture and
// E0/F0 prefix folding into one strobe per key event.
module ps2_kbd_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       extended,
    output logic       released,
    output logic       strobe,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          r_clk_f;
    logic          r_dat_f;
    logic          r_clk_prev;
    logic [FW-1:0] r_clk_cnt;
    logic [FW-1:0] r_dat_cnt;
    logic [TW-1:0] r_tcnt;

    state_t        r_state;
    state_t        w_state_nx;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nx;
    logic [2:0]    r_bitcnt;
    logic [2:0]    w_bitcnt_nx;
    logic          r_par;
    logic          w_par_nx;

    logic          w_fall;
    logic          w_tmo;
    logic          w_acc;
    logic          w_perr;
    logic          w_ferr;
    logic          r_ext_pend;
    logic          r_rel_pend;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    // Filtered value flips only after FILTER consecutive disagreeing samples
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_f   <= 1'b1;
            r_clk_cnt <= '0;
        end else if (r_clk_sync[1] == r_clk_f) begin
            r_clk_cnt <= '0;
        end else if (r_clk_cnt == FW'(FILTER - 1)) begin
            r_clk_f   <= r_clk_sync[1];
            r_clk_cnt <= '0;
        end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dat_f   <= 1'b1;
            r_dat_cnt <= '0;
        end else if (r_dat_sync[1] == r_dat_f) begin
            r_dat_cnt <= '0;
        end else if (r_dat_cnt == FW'(FILTER - 1)) begin
            r_dat_f   <= r_dat_sync[1];
            r_dat_cnt <= '0;
        end else begin
            r_dat_cnt <= r_dat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_prev <= r_clk_f;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_f;
    assign w_tmo  = (r_state != S_IDLE) && (r_tcnt >= TW'(TIMEOUT));

    always_ff @(posedge clk_sys) begin
        if (reset || w_fall || r_state == S_IDLE) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_par    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_shift  <= w_shift_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_par    <= w_par_nx;
        end
    end

    // An edge takes priority over a timeout landing in the same cycle
    always_comb begin
        w_state_nx  = r_state;
        w_shift_nx  = r_shift;
        w_bitcnt_nx = r_bitcnt;
        w_par_nx    = r_par;
        w_acc       = 1'b0;
        w_perr      = 1'b0;
        w_ferr      = 1'b0;
        if (w_fall) begin
            unique case (r_state)
                S_IDLE: begin
                    if (!r_dat_f) begin
                        w_state_nx  = S_DATA;
                        w_shift_nx  = '0;
                        w_bitcnt_nx = '0;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
                S_DATA: begin
                    w_shift_nx  = {r_dat_f, r_shift[7:1]};
                    w_bitcnt_nx = r_bitcnt + 1'b1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_nx = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_par_nx   = r_dat_f;
                    w_state_nx = S_STOP;
                end
                S_STOP: begin
                    w_state_nx = S_IDLE;
                    if (!r_dat_f) begin
                        w_ferr = 1'b1;
                    end else if ((^r_shift ^ r_par) != 1'b1) begin
                        w_perr = 1'b1;
                    end else begin
                        w_acc = 1'b1;
                    end
                end
            endcase
        end else if (w_tmo) begin
            w_ferr     = 1'b1;
            w_state_nx = S_IDLE;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            code       <= '0;
            extended   <= 1'b0;
            released   <= 1'b0;
            strobe     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            r_ext_pend <= 1'b0;
            r_rel_pend <= 1'b0;
        end else begin
            strobe     <= 1'b0;
            parity_err <= w_perr;
            frame_err  <= w_ferr;
            if (w_perr || w_ferr) begin
                r_ext_pend <= 1'b0;
                r_rel_pend <= 1'b0;
            end else if (w_acc) begin
                if (r_shift == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_rel_pend <= 1'b1;
                end else begin
                    code       <= r_shift;
                    extended   <= r_ext_pend;
                    released   <= r_rel_pend;
                    strobe     <= 1'b1;
                    r_ext_pend <= 1'b0;
                    r_rel_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: an event-level model predicts each
// frame's outcome; a per-cycle monitor compares pulses and held outputs.
module tb_ps2_kbd_rx;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 1000;
    localparam int PH      = 40;
    localparam int LAT     = 11;

    logic       clk_sys  = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       extended;
    logic       released;
    logic       strobe;
    logic       parity_err;
    logic       frame_err;

    ps2_kbd_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code      (code),
        .extended  (extended),
        .released  (released),
        .strobe    (strobe),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        int         lat;
    } ev_t;

    ev_t        q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_code = 8'h00;
    logic       m_ext  = 1'b0;
    logic       m_rel  = 1'b0;
    bit         p_ext  = 1'b0;
    bit         p_rel  = 1'b0;
    int         n_str  = 0;
    int         n_perr = 0;
    int         n_ferr = 0;
    int         last_fall = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] frm(input logic [7:0] b,
                                        input bit par_ok, input bit stop_ok);
        logic p;
        p = ~^b;
        if (!par_ok) p = ~p;
        return {logic'(stop_ok), p, b, 1'b0};
    endfunction

    function automatic void push_err(input int kind, input int lat);
        ev_t e;
        e.kind = kind;
        e.code = 8'h00;
        e.ext  = 1'b0;
        e.rel  = 1'b0;
        e.lat  = lat;
        q.push_back(e);
        p_ext = 1'b0;
        p_rel = 1'b0;
    endfunction

    function automatic void model(input logic [7:0] b, input bit par_ok,
                                  input bit stop_ok);
        ev_t e;
        if (!stop_ok) begin
            push_err(2, LAT);
        end else if (!par_ok) begin
            push_err(1, LAT);
        end else if (b == 8'hE0) begin
            p_ext = 1'b1;
        end else if (b == 8'hF0) begin
            p_rel = 1'b1;
        end else begin
            e.kind = 0;
            e.code = b;
            e.ext  = p_ext;
            e.rel  = p_rel;
            e.lat  = LAT;
            q.push_back(e);
            p_ext = 1'b0;
            p_rel = 1'b0;
        end
    endfunction

    task automatic send_raw(input logic [10:0] bits, input int n,
                            input int glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (i == glitch) begin
                repeat (15) @(posedge clk_sys);
                #1 ps2_clk = 1'b0;
                repeat (3) @(posedge clk_sys);
                #1 ps2_clk = 1'b1;
                repeat (PH - 18) @(posedge clk_sys);
            end else begin
                repeat (PH) @(posedge clk_sys);
            end
            #1 ps2_clk = 1'b0;
            last_fall = cyc;
            repeat (PH) @(posedge clk_sys);
            #1 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (PH) @(posedge clk_sys);
    endtask

    task automatic settle();
        repeat (20) @(posedge clk_sys);
        #1;
        chk("event_delivered", q.size(), 0);
        q.delete();
    endtask

    task automatic send(input logic [7:0] b, input bit par_ok = 1'b1,
                        input bit stop_ok = 1'b1, input int glitch = -1);
        model(b, par_ok, stop_ok);
        send_raw(frm(b, par_ok, stop_ok), 11, glitch);
        settle();
    endtask

    always @(negedge clk_sys) begin
        ev_t e;
        int  np;
        int  act;
        int  lat;
        np = int'(strobe === 1'b1) + int'(parity_err === 1'b1)
           + int'(frame_err === 1'b1);
        if (reset) begin
            m_code = 8'h00;
            m_ext  = 1'b0;
            m_rel  = 1'b0;
        end
        if (np > 0) begin
            chk("pulse_exclusive", np, 1);
            act = (strobe === 1'b1) ? 0 : (parity_err === 1'b1) ? 1 : 2;
            if (act == 0) n_str++;
            if (act == 1) n_perr++;
            if (act == 2) n_ferr++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse got kind %0d want none", act);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", act, e.kind);
                lat = cyc - last_fall;
                checks++;
                if (lat < e.lat - 1 || lat > e.lat + 1) begin
                    errors++;
                    $display("FAIL pulse_latency got %0d want %0d", lat, e.lat);
                end
                if (act == 0 && e.kind == 0) begin
                    m_code = e.code;
                    m_ext  = e.ext;
                    m_rel  = e.rel;
                end
            end
        end
        if (!reset) begin
            chk("hold_code", code, m_code);
            chk("hold_ext", extended, m_ext);
            chk("hold_rel", released, m_rel);
        end
    end

    initial begin
        int s0;
        reset = 1'b1;
        repeat (4) @(posedge clk_sys);
        #1 reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_code", code, 8'h00);
        chk("rst_ext", extended, 0);
        chk("rst_rel", released, 0);
        chk("rst_pulses", {strobe, parity_err, frame_err}, 0);

        s0 = n_str;
        send(8'h1C);
        chk("t1_code", code, 8'h1C);
        chk("t1_ext", extended, 0);
        chk("t1_rel", released, 0);
        chk("t1_strobes", n_str - s0, 1);

        s0 = n_str;
        send(8'hE0);
        send(8'hF0);
        chk("t2_no_prefix_strobe", n_str - s0, 0);
        send(8'h75);
        chk("t2_code", code, 8'h75);
        chk("t2_ext", extended, 1);
        chk("t2_rel", released, 1);
        chk("t2_strobes", n_str - s0, 1);
        send(8'h1C);
        chk("t2b_ext", extended, 0);
        chk("t2b_rel", released, 0);

        send(8'hF0);
        s0 = n_str;
        send(8'h1C, 1'b0);
        chk("t3_perr", n_perr, 1);
        chk("t3_no_strobe", n_str - s0, 0);
        send(8'h1C);
        chk("t3_rel_dropped", released, 0);

        s0 = n_str;
        send(8'h29, 1'b1, 1'b0);
        chk("t4_ferr", n_ferr, 1);
        chk("t4_no_strobe", n_str - s0, 0);

        send(8'hE0);
        push_err(2, TIMEOUT + 12);
        send_raw(frm(8'h12, 1'b1, 1'b1), 5, -1);
        repeat (TIMEOUT + 10) @(posedge clk_sys);
        settle();
        chk("t5_ferr", n_ferr, 2);
        send(8'h5A);
        chk("t5_code", code, 8'h5A);
        chk("t5_ext_dropped", extended, 0);

        send(8'hF0);
        push_err(2, LAT);
        send_raw(11'h001, 1, -1);
        settle();
        chk("t6_ferr", n_ferr, 3);
        send(8'h1C);
        chk("t6_rel_dropped", released, 0);

        send(8'h5A);
        send(8'h1C, 1'b1, 1'b1, 4);
        chk("t7_glitch_code", code, 8'h1C);

        send(8'hE0);
        s0 = n_str + n_perr + n_ferr;
        send_raw(frm(8'h1C, 1'b1, 1'b1), 6, -1);
        @(posedge clk_sys);
        #1 reset = 1'b1;
        @(posedge clk_sys);
        #1 reset = 1'b0;
        p_ext = 1'b0;
        p_rel = 1'b0;
        @(negedge clk_sys);
        chk("t8_rst_code", code, 8'h00);
        chk("t8_rst_ext", extended, 0);
        settle();
        chk("t8_no_pulse", n_str + n_perr + n_ferr - s0, 0);
        send(8'h1C);
        chk("t8_code", code, 8'h1C);
        chk("t8_ext", extended, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
